// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and ASCII constants for the LCD datapath
package lcd_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FORMAT
    } b2a_state_t;

    typedef logic [7:0] ascii_t;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble correction: add 3 when nibble >= 5
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Correct the nibble so the following left shift carries into the next decade
    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/bin2ascii_seq.sv
// rtl/bin2ascii_seq.sv - serial double-dabble binary to ASCII decimal converter
module bin2ascii_seq
    import lcd_pkg::*;
#(
    parameter int BIN_W    = 9,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [BIN_W-1:0]       bin_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [DIGITS-1:0][7:0] dec_o,
    output logic                   valid_o,
    output logic                   busy_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // The digit count must be able to represent the largest binary input
    if (10 ** DIGITS <= 2 ** BIN_W - 1) begin : g_param_check
        $error("bin2ascii_seq: DIGITS too small for BIN_W");
    end

    // {bcd, bin} kept as one register so the shift moves bits across the seam
    logic [WORK_W-1:0]         work;
    logic [BCD_W-1:0]          bcd_adj;
    logic [CNT_W-1:0]          cnt;
    b2a_state_t                state;
    ascii_t [DIGITS-1:0]       fmt;
    ascii_t [DIGITS-1:0]       rst_val;
    logic                      lead;
    logic [3:0]                nib;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (work[BIN_W + 4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
        assign rst_val[g] = (g == 0 || BLANK_LZ == 0) ? ASCII_ZERO : ASCII_SPACE;
    end

    assign ready_o = rst_ni && (state == IDLE);

    // ASCII formatting with optional blanking of zeros left of the first nonzero digit
    always_comb begin
        fmt  = '0;
        nib  = 4'd0;
        lead = (BLANK_LZ != 0);
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = work[BIN_W + 4*i +: 4];
            if (lead && i != 0 && nib == 4'd0) begin
                fmt[i] = ASCII_SPACE;
            end else begin
                fmt[i] = ASCII_ZERO + {4'd0, nib};
                lead   = 1'b0;
            end
        end
    end

    // Conversion sequencer: accept, BIN_W shift-add-3 steps, one format step
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= IDLE;
            work    <= '0;
            cnt     <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            dec_o   <= rst_val;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        work   <= {{BCD_W{1'b0}}, bin_i};
                        cnt    <= CNT_W'(BIN_W);
                        busy_o <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= {bcd_adj, work[BIN_W-1:0]} << 1;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FORMAT;
                    end
                end
                FORMAT: begin
                    dec_o   <= fmt;
                    valid_o <= 1'b1;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2ascii_seq.sv
// tb/tb_bin2ascii_seq.sv - self-checking bench for bin2ascii_seq
module tb_bin2ascii_seq;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [8:0]      bin = '0;
    logic            valid = 1'b0;
    logic            ready_o;
    logic [2:0][7:0] dec_o;
    logic            valid_o;
    logic            busy_o;

    logic [8:0]      bin2 = '0;
    logic            valid2 = 1'b0;
    logic            ready2;
    logic [2:0][7:0] dec2;
    logic            valid2_o;
    logic            busy2;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // model state
    int          rem = 0;
    logic [23:0] held = 24'h202030;
    logic [23:0] pending = 24'h202030;
    logic        vexp = 1'b0;

    always #5 clk = ~clk;

    bin2ascii_seq #(.BIN_W(9), .DIGITS(3), .BLANK_LZ(1)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .bin_i   (bin),
        .valid_i (valid),
        .ready_o (ready_o),
        .dec_o   (dec_o),
        .valid_o (valid_o),
        .busy_o  (busy_o)
    );

    bin2ascii_seq #(.BIN_W(9), .DIGITS(3), .BLANK_LZ(0)) dut_nb (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .bin_i   (bin2),
        .valid_i (valid2),
        .ready_o (ready2),
        .dec_o   (dec2),
        .valid_o (valid2_o),
        .busy_o  (busy2)
    );

    function automatic logic [23:0] fmt(input int v, input bit blank);
        int d2, d1, d0;
        logic [23:0] r;
        d2 = (v / 100) % 10;
        d1 = (v / 10) % 10;
        d0 = v % 10;
        r[23:16] = (blank && d2 == 0) ? 8'h20 : 8'(48 + d2);
        r[15:8]  = (blank && d2 == 0 && d1 == 0) ? 8'h20 : 8'(48 + d1);
        r[7:0]   = 8'(48 + d0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference behaviour: a conversion occupies 10 edges after the accept edge
    always @(posedge clk) begin
        if (!rst_n) begin
            rem  = 0;
            held = fmt(0, 1);
            vexp = 1'b0;
        end else begin
            vexp = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    held = pending;
                    vexp = 1'b1;
                end
            end else if (valid) begin
                rem = 10;
                pending = fmt(int'(bin), 1);
            end
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("valid_o", {31'd0, valid_o}, {31'd0, vexp});
            chk("busy_o", {31'd0, busy_o}, {31'd0, rem > 0});
            chk("ready_o", {31'd0, ready_o}, {31'd0, rst_n && rem == 0});
            chk("dec_o", {8'd0, dec_o}, {8'd0, held});
        end
    end

    task automatic send(input int v, output int ac);
        bit ok;
        @(posedge clk); #1;
        valid = 1'b1;
        bin = 9'(v);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (ready_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        ac = cyc;
        valid = 1'b0;
    endtask

    task automatic wait_valid(output int vc, output int nb);
        vc = -1;
        nb = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_o) begin
                vc = cyc;
                break;
            end
            if (busy_o) nb++;
        end
        if (vc < 0) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (valid_o) cnt++;
        end
    endtask

    initial begin
        int ac, ac2, v1, v2, nb, cnt;
        bit seen;

        chk("model_511", {8'd0, fmt(511, 1)}, 32'h353131);
        chk("model_105", {8'd0, fmt(105, 1)}, 32'h313035);
        chk("model_42", {8'd0, fmt(42, 1)}, 32'h203432);
        chk("model_7_nb", {8'd0, fmt(7, 0)}, 32'h303037);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // idle after reset
        count_valid(5, cnt);
        chk("idle_no_valid", cnt, 0);
        chk("idle_ready", {31'd0, ready_o}, 32'd1);
        chk("idle_dec", {8'd0, dec_o}, 32'h202030);
        chk("idle_dec_nb", {8'd0, dec2}, 32'h303030);

        // zero input, latency
        send(0, ac);
        wait_valid(v1, nb);
        chk("lat_zero", v1 - ac, 10);
        chk("dec_zero", {8'd0, dec_o}, 32'h202030);

        // maximum input, busy length
        send(511, ac);
        wait_valid(v1, nb);
        chk("lat_511", v1 - ac, 10);
        chk("busy_len_511", nb, 10);
        chk("dec_511", {8'd0, dec_o}, 32'h353131);

        // back-to-back: 105 then 7 with valid held
        @(posedge clk); #1;
        valid = 1'b1;
        bin = 9'd105;
        for (int k = 0; k < 40 && !ready_o; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        ac = cyc;
        bin = 9'd7;
        wait_valid(v1, nb);
        chk("dec_105", {8'd0, dec_o}, 32'h313035);
        @(posedge clk); #1;
        ac2 = cyc;
        valid = 1'b0;
        wait_valid(v2, nb);
        chk("b2b_gap", v2 - v1, 11);
        chk("b2b_accept_gap", ac2 - ac, 11);
        chk("dec_7", {8'd0, dec_o}, 32'h202037);

        // request while busy is ignored
        send(42, ac);
        repeat (3) @(posedge clk);
        #1;
        bin = 9'd300;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        wait_valid(v1, nb);
        chk("lat_42", v1 - ac, 10);
        chk("dec_42", {8'd0, dec_o}, 32'h203432);
        count_valid(20, cnt);
        chk("busy_ignored", cnt, 0);

        // reset during shift 4 of 255
        send(255, ac);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        count_valid(20, cnt);
        chk("abort_no_valid", cnt, 0);
        chk("abort_dec", {8'd0, dec_o}, 32'h202030);
        send(255, ac);
        wait_valid(v1, nb);
        chk("dec_255", {8'd0, dec_o}, 32'h323535);

        // no blanking variant
        @(posedge clk); #1;
        valid2 = 1'b1;
        bin2 = 9'd7;
        for (int k = 0; k < 40 && !ready2; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        valid2 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid2_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk("nb_valid_seen", {31'd0, seen}, 32'd1);
        chk("dec_7_nb", {8'd0, dec2}, 32'h303037);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
